apb_requester_arbiter: RTL and testbench

- Shares one APB completer port (e.g. the FIC-side fabric APB segment feeding the address-decode splitter) between two APB requesters, e.g. the MSS fabric interface and a fabric debug/config master.
- Round-robin arbitration per transfer, with a registered SETUP/ACCESS sequencer on the completer side.
- A per-transfer timeout aborts a hung completer and returns an error to the requester that owns the transfer.

---
 rtl/apb_requester_arbiter_if.sv | 27 ++
 rtl/apb_requester_arbiter.sv | 135 +++++++++++++
 tb/tb_apb_requester_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_arbiter_if.sv
// APB bus bundle shared by the requester-facing and completer-facing sides of
// apb_requester_arbiter.
//   master : drives psel/penable/pwrite/paddr/pwdata, receives prdata/pready/pslverr
//   slave  : receives the request signals, drives the response signals
interface apb_requester_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_requester_arbiter.sv
// Two-requester APB arbiter sharing one completer port.
// Round-robin grant per transfer, registered SETUP/ACCESS sequencer on the
// completer side, and an optional per-transfer timeout that aborts a hung
// completer and returns an error to the owning requester.
// Ports:
//   pclk, presetn  : clock, asynchronous active-low reset
//   rq0, rq1       : requester-facing APB ports (slave modport)
//   cp             : completer-facing APB port (master modport)
//   timeout_pulse  : one-cycle pulse on each timeout abort
//   grant_id       : requester owning the current or last transfer
module apb_requester_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           pclk,
  input  logic                           presetn,
  apb_requester_arbiter_if.slave         rq0,
  apb_requester_arbiter_if.slave         rq1,
  apb_requester_arbiter_if.master        cp,
  output logic                           timeout_pulse,
  output logic                           grant_id
);

  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int unsigned CntWidth  = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic                  grant_q;
  logic                  last_grant_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CntWidth-1:0]   cnt_q;

  logic                  any_req;
  logic                  winner;
  logic                  resp_done;
  logic                  resp_timeout;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  sel0;
  logic                  sel1;

  // Arbitration and completion decode.
  always_comb begin
    any_req = rq0.psel | rq1.psel;
    // On a tie the requester that did not win last time goes next.
    if (rq0.psel && rq1.psel) begin
      winner = ~last_grant_q;
    end else begin
      winner = rq1.psel;
    end
    resp_done    = (state_q == StAccess) && cp.pready;
    resp_timeout = TimeoutEn && (state_q == StAccess) && !cp.pready && (cnt_q == CntLimit);
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (any_req) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (resp_done || resp_timeout) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Latched transfer attributes, grant tracking and the wait counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      if (state_q == StIdle && any_req) begin
        grant_q      <= winner;
        last_grant_q <= winner;
        write_q      <= winner ? rq1.pwrite : rq0.pwrite;
        addr_q       <= winner ? rq1.paddr  : rq0.paddr;
        wdata_q      <= winner ? rq1.pwdata : rq0.pwdata;
      end
      if (TimeoutEn && state_q == StAccess && !cp.pready && !resp_timeout) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // FSM and response outputs. The completer response is passed through
  // combinationally to the owner only in the completing ACCESS cycle.
  always_comb begin
    cp.psel    = (state_q != StIdle);
    cp.penable = (state_q == StAccess);
    cp.pwrite  = write_q;
    cp.paddr   = addr_q;
    cp.pwdata  = wdata_q;

    resp_valid = resp_done | resp_timeout;
    resp_err   = resp_timeout | cp.pslverr;
    resp_data  = resp_timeout ? '0 : cp.prdata;

    sel0 = resp_valid & ~grant_q;
    sel1 = resp_valid & grant_q;

    rq0.pready  = sel0;
    rq0.pslverr = sel0 & resp_err;
    rq0.prdata  = sel0 ? resp_data : '0;
    rq1.pready  = sel1;
    rq1.pslverr = sel1 & resp_err;
    rq1.prdata  = sel1 ? resp_data : '0;

    timeout_pulse = resp_timeout;
    grant_id      = grant_q;
  end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
`timescale 1ns/1ps
module tb_apb_requester_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- main DUT (TIMEOUT_CYCLES = 4) ----------------
  apb_requester_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rq0_bus ();
  apb_requester_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rq1_bus ();
  apb_requester_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cp_bus ();
  logic timeout_pulse;
  logic grant_id;

  apb_requester_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .rq0           (rq0_bus),
    .rq1           (rq1_bus),
    .cp            (cp_bus),
    .timeout_pulse (timeout_pulse),
    .grant_id      (grant_id)
  );

  logic          r_psel    [2];
  logic          r_penable [2];
  logic          r_pwrite  [2];
  logic [31:0]   r_paddr   [2];
  logic [31:0]   r_pwdata  [2];

  assign rq0_bus.psel    = r_psel[0];
  assign rq0_bus.penable = r_penable[0];
  assign rq0_bus.pwrite  = r_pwrite[0];
  assign rq0_bus.paddr   = r_paddr[0];
  assign rq0_bus.pwdata  = r_pwdata[0];
  assign rq1_bus.psel    = r_psel[1];
  assign rq1_bus.penable = r_penable[1];
  assign rq1_bus.pwrite  = r_pwrite[1];
  assign rq1_bus.paddr   = r_paddr[1];
  assign rq1_bus.pwdata  = r_pwdata[1];

  // Completer: pready after cfg_waits wait cycles, read data derived from address.
  int unsigned cfg_waits = 0;
  logic        cfg_err   = 1'b0;
  int unsigned acc_cnt   = 0;

  function automatic logic [31:0] cp_data(input logic [31:0] a);
    if (a == 32'h4000_0000) return 32'h1111_1111;
    if (a == 32'h5000_0000) return 32'h2222_2222;
    return a ^ 32'hA5A5_A5A5;
  endfunction

  assign cp_bus.pready  = cp_bus.psel && cp_bus.penable && (acc_cnt == cfg_waits);
  assign cp_bus.pslverr = cfg_err;
  assign cp_bus.prdata  = cp_data(cp_bus.paddr);

  always @(posedge pclk) begin
    if (cp_bus.psel && cp_bus.penable && !cp_bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  int to_cnt = 0;
  always @(negedge pclk) if (timeout_pulse === 1'b1) to_cnt <= to_cnt + 1;

  // ---------------- second DUT (timeout disabled) ----------------
  apb_requester_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_rq0 ();
  apb_requester_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_rq1 ();
  apb_requester_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_cp ();
  logic b_to;
  logic b_gid;
  logic b_psel = 1'b0;
  logic b_penable = 1'b0;

  apb_requester_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_nto (
    .pclk          (pclk),
    .presetn       (presetn),
    .rq0           (b_rq0),
    .rq1           (b_rq1),
    .cp            (b_cp),
    .timeout_pulse (b_to),
    .grant_id      (b_gid)
  );

  assign b_rq0.psel    = b_psel;
  assign b_rq0.penable = b_penable;
  assign b_rq0.pwrite  = 1'b0;
  assign b_rq0.paddr   = 32'h4000_0020;
  assign b_rq0.pwdata  = 32'h0;
  assign b_rq1.psel    = 1'b0;
  assign b_rq1.penable = 1'b0;
  assign b_rq1.pwrite  = 1'b0;
  assign b_rq1.paddr   = 32'h0;
  assign b_rq1.pwdata  = 32'h0;
  assign b_cp.prdata   = 32'hFFFF_FFFF;
  assign b_cp.pready   = 1'b0;
  assign b_cp.pslverr  = 1'b0;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is "busy" from grant until response;
  // m_age counts cycles since the grant (0 = completer SETUP, >=1 = ACCESS,
  // and m_age-1 is the number of ACCESS cycles already spent waiting).
  logic        m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_grant = 1'b0, m_write = 1'b0;
  int          m_age = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        n_busy, n_owner, n_last, n_grant, n_write;
  int          n_age;
  logic [31:0] n_addr, n_wdata;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1; m_grant <= 1'b0;
      m_write <= 1'b0; m_age <= 0; m_addr <= '0; m_wdata <= '0;
    end else begin
      m_busy <= n_busy; m_owner <= n_owner; m_last <= n_last; m_grant <= n_grant;
      m_write <= n_write; m_age <= n_age; m_addr <= n_addr; m_wdata <= n_wdata;
    end
  end

  always @(negedge pclk) begin
    logic in_acc, done, tmo, rsp, rerr, w;
    logic [31:0] rdat;
    in_acc = m_busy && (m_age >= 1);
    done   = in_acc && cp_bus.pready;
    tmo    = in_acc && !cp_bus.pready && (TO != 0) && ((m_age - 1) == int'(TO));
    rsp    = done || tmo;
    rdat   = tmo ? 32'h0 : cp_bus.prdata;
    rerr   = tmo ? 1'b1 : cp_bus.pslverr;

    chk("cp_psel",    cp_bus.psel,    m_busy);
    chk("cp_penable", cp_bus.penable, in_acc);
    chk("cp_pwrite",  cp_bus.pwrite,  m_write);
    chk("cp_paddr",   cp_bus.paddr,   m_addr);
    chk("cp_pwdata",  cp_bus.pwdata,  m_wdata);
    chk("rq0_pready", rq0_bus.pready, rsp && !m_owner);
    chk("rq0_pslverr", rq0_bus.pslverr, rsp && !m_owner && rerr);
    chk("rq0_prdata", rq0_bus.prdata, (rsp && !m_owner) ? rdat : 32'h0);
    chk("rq1_pready", rq1_bus.pready, rsp && m_owner);
    chk("rq1_pslverr", rq1_bus.pslverr, rsp && m_owner && rerr);
    chk("rq1_prdata", rq1_bus.prdata, (rsp && m_owner) ? rdat : 32'h0);
    chk("timeout_pulse", timeout_pulse, tmo);
    chk("grant_id",   grant_id,       m_grant);

    n_busy = m_busy; n_owner = m_owner; n_last = m_last; n_grant = m_grant;
    n_write = m_write; n_age = m_age; n_addr = m_addr; n_wdata = m_wdata;
    if (!m_busy) begin
      if (r_psel[0] || r_psel[1]) begin
        w = (r_psel[0] && r_psel[1]) ? !m_last : r_psel[1];
        n_busy = 1'b1; n_age = 0; n_owner = w; n_last = w; n_grant = w;
        n_write = r_pwrite[w]; n_addr = r_paddr[w]; n_wdata = r_pwdata[w];
      end
    end else if (rsp) begin
      n_busy = 1'b0;
    end else begin
      n_age = m_age + 1;
    end
  end

  // ---------------- requester task ----------------
  // Called just after a rising edge; returns just after the edge that ends
  // the completing cycle. lat counts cycles from the requester SETUP cycle.
  task automatic xfer(input int id, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat, output logic gid);
    int cyc;
    bit got;
    rdata = '0; err = 1'b0; lat = -1; gid = 1'b0;
    r_psel[id] = 1'b1; r_penable[id] = 1'b0; r_pwrite[id] = wr;
    r_paddr[id] = addr; r_pwdata[id] = wdata;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge pclk);
      if ((id == 0 ? rq0_bus.pready : rq1_bus.pready) === 1'b1) begin
        got = 1;
        rdata = (id == 0) ? rq0_bus.prdata : rq1_bus.prdata;
        err = (id == 0) ? rq0_bus.pslverr : rq1_bus.pslverr;
        gid = grant_id;
        lat = cyc;
      end
      @(posedge pclk); #1;
      if (!got) begin
        r_penable[id] = 1'b1;
        cyc++;
      end
    end
    r_psel[id] = 1'b0; r_penable[id] = 1'b0;
    if (!got) begin
      n_vec++; n_miss++;
      $display("FAIL xfer_rq%0d: no pready within %0d cycles", id, cyc);
    end
  endtask

  int   exp_lat0 [3] = '{2, 5, 5};
  int   exp_lat1 [3] = '{5, 5, 5};
  logic order_q [$];

  initial begin
    logic [31:0] rd0, rd1;
    logic e0, e1, g0, g1;
    int l0, l1, to_before, b_rdy, b_tmo;

    for (int i = 0; i < 2; i++) begin
      r_psel[i] = 0; r_penable[i] = 0; r_pwrite[i] = 0; r_paddr[i] = 0; r_pwdata[i] = 0;
    end
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_cp_psel", cp_bus.psel, 1'b0);
    chk("reset_grant_id", grant_id, 1'b0);
    chk("reset_cp_paddr", cp_bus.paddr, 32'h0);
    chk("reset_rq0_pready", rq0_bus.pready, 1'b0);
    #2 presetn = 1'b1;
    @(posedge pclk); #1;

    // Simultaneous reads right after reset: rq0 first, one IDLE, then rq1.
    fork
      xfer(0, 1'b0, 32'h4000_0000, 32'h0, rd0, e0, l0, g0);
      xfer(1, 1'b0, 32'h5000_0000, 32'h0, rd1, e1, l1, g1);
    join
    chk("sim_rq0_rdata", rd0, 32'h1111_1111);
    chk("sim_rq0_lat", l0, 2);
    chk("sim_rq0_gid", g0, 1'b0);
    chk("sim_rq1_rdata", rd1, 32'h2222_2222);
    chk("sim_rq1_lat", l1, 5);
    chk("sim_rq1_gid", g1, 1'b1);

    // Both keep requesting for 6 transfers: grants must alternate.
    fork
      begin
        logic [31:0] rd; logic e, g; int l;
        for (int k = 0; k < 3; k++) begin
          xfer(0, 1'b0, 32'h4000_0100 + 32'(k * 4), 32'h0, rd, e, l, g);
          order_q.push_back(1'b0);
          chk("rr_rq0_rdata", rd, (32'h4000_0100 + 32'(k * 4)) ^ 32'hA5A5_A5A5);
          chk("rr_rq0_lat", l, exp_lat0[k]);
        end
      end
      begin
        logic [31:0] rd; logic e, g; int l;
        for (int k = 0; k < 3; k++) begin
          xfer(1, 1'b0, 32'h5000_0100 + 32'(k * 4), 32'h0, rd, e, l, g);
          order_q.push_back(1'b1);
          chk("rr_rq1_rdata", rd, (32'h5000_0100 + 32'(k * 4)) ^ 32'hA5A5_A5A5);
          chk("rr_rq1_lat", l, exp_lat1[k]);
        end
      end
    join
    chk("rr_count", order_q.size(), 6);
    for (int k = 0; k < order_q.size(); k++) chk("rr_order", order_q[k], k % 2);

    // Single zero-wait write from rq0.
    xfer(0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, rd0, e0, l0, g0);
    chk("wr_lat", l0, 2);
    chk("wr_err", e0, 1'b0);
    chk("wr_cp_paddr", cp_bus.paddr, 32'h4000_0010);
    chk("wr_cp_pwdata", cp_bus.pwdata, 32'hDEAD_BEEF);
    chk("wr_cp_pwrite", cp_bus.pwrite, 1'b1);

    // Three wait states then an error response to rq1.
    cfg_waits = 3; cfg_err = 1'b1; to_before = to_cnt;
    xfer(1, 1'b0, 32'h5000_0040, 32'h0, rd1, e1, l1, g1);
    chk("ws_lat", l1, 5);
    chk("ws_err", e1, 1'b1);
    chk("ws_rdata", rd1, 32'h5000_0040 ^ 32'hA5A5_A5A5);
    chk("ws_no_timeout", to_cnt - to_before, 0);
    cfg_err = 1'b0;

    // Hung completer: abort after 4 waiting ACCESS cycles.
    cfg_waits = 1000; to_before = to_cnt;
    xfer(0, 1'b1, 32'h4000_0080, 32'h1234_5678, rd0, e0, l0, g0);
    chk("to_lat", l0, 6);
    chk("to_err", e0, 1'b1);
    chk("to_rdata", rd0, 32'h0);
    @(negedge pclk);
    chk("to_pulses", to_cnt - to_before, 1);
    chk("to_cp_psel_drop", cp_bus.psel, 1'b0);
    @(posedge pclk); #1;

    // Timeout disabled: the same hang stalls indefinitely.
    b_psel = 1'b1;
    @(posedge pclk); #1;
    b_penable = 1'b1;
    b_rdy = 0; b_tmo = 0;
    repeat (30) begin
      @(negedge pclk);
      if (b_rq0.pready === 1'b1) b_rdy++;
      if (b_to === 1'b1) b_tmo++;
    end
    chk("nto_no_pready", b_rdy, 0);
    chk("nto_no_pulse", b_tmo, 0);
    chk("nto_cp_psel", b_cp.psel, 1'b1);
    chk("nto_cp_penable", b_cp.penable, 1'b1);
    @(posedge pclk); #1;
    b_psel = 1'b0; b_penable = 1'b0;

    // Reset in the middle of a wait-stated transfer.
    r_psel[0] = 1'b1; r_pwrite[0] = 1'b0; r_paddr[0] = 32'h4000_0300;
    @(posedge pclk); #1;
    r_penable[0] = 1'b1;
    @(posedge pclk);
    @(posedge pclk);
    #3 presetn = 1'b0;
    #1;
    chk("rst_cp_psel", cp_bus.psel, 1'b0);
    chk("rst_cp_penable", cp_bus.penable, 1'b0);
    chk("rst_rq0_pready", rq0_bus.pready, 1'b0);
    chk("rst_rq1_pready", rq1_bus.pready, 1'b0);
    chk("rst_nto_cp_psel", b_cp.psel, 1'b0);
    r_psel[0] = 1'b0; r_penable[0] = 1'b0; cfg_waits = 0;
    @(posedge pclk); #3 presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1, 1'b0, 32'h5000_0000, 32'h0, rd1, e1, l1, g1);
    chk("post_rq1_lat", l1, 2);
    chk("post_rq1_gid", g1, 1'b1);
    chk("post_rq1_rdata", rd1, 32'h2222_2222);
    fork
      xfer(0, 1'b0, 32'h4000_0000, 32'h0, rd0, e0, l0, g0);
      xfer(1, 1'b0, 32'h5000_0000, 32'h0, rd1, e1, l1, g1);
    join
    chk("post_tie_rq0_lat", l0, 2);
    chk("post_tie_rq0_gid", g0, 1'b0);
    chk("post_tie_rq1_lat", l1, 5);

    repeat (2) @(posedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
